// File: rtl/router_pkg.sv
// Shared definitions for the mesh router input port: direction indices,
// flit type codes, header field layout and the port controller state encoding.
package router_pkg;

    // Output direction indices; also the bit positions in the one-hot req_dir
    typedef enum logic [2:0] {
        DIR_XP    = 3'd0,
        DIR_XM    = 3'd1,
        DIR_YP    = 3'd2,
        DIR_YM    = 3'd3,
        DIR_LOCAL = 3'd4
    } dir_e;

    // Flit type codes carried in the two most significant flit bits
    typedef enum logic [1:0] {
        FLIT_BODY      = 2'b00,
        FLIT_HEAD      = 2'b01,
        FLIT_TAIL      = 2'b10,
        FLIT_HEAD_TAIL = 2'b11
    } flit_type_e;

    // Width of the type field; destination X starts just below it, Y below X
    localparam int TYPE_W = 2;

    // Input port controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUTE  = 2'd1,
        ST_REQ    = 2'd2,
        ST_ACTIVE = 2'd3
    } state_e;

    // Head and head+tail both open a packet (low type bit set)
    function automatic logic is_head(input logic [TYPE_W-1:0] t);
        return t[0];
    endfunction

    // Tail and head+tail both close a packet (high type bit set)
    function automatic logic is_tail(input logic [TYPE_W-1:0] t);
        return t[1];
    endfunction

endpackage

// File: rtl/router_input_port_if.sv
// Link/crossbar/allocator signal bundle of one router input port.
// The credit_out signal only exists when CREDIT_RETURN_EN is defined.
interface router_input_port_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_DIR = 5
);
    logic               in_valid;
    logic [WIDTH-1:0]   in_flit;
    logic               in_ready;
    logic               req;
    logic [NUM_DIR-1:0] req_dir;
    logic               grant;
    logic               out_valid;
    logic [WIDTH-1:0]   out_flit;
    logic               out_ready;
    logic               err_drop;
`ifdef CREDIT_RETURN_EN
    logic               credit_out;
`endif

    // Environment side: upstream link, allocator and crossbar
    modport master (
        output in_valid, in_flit, grant, out_ready,
        input  in_ready, req, req_dir, out_valid, out_flit, err_drop
`ifdef CREDIT_RETURN_EN
        , input credit_out
`endif
    );

    // Input port side
    modport slave (
        input  in_valid, in_flit, grant, out_ready,
        output in_ready, req, req_dir, out_valid, out_flit, err_drop
`ifdef CREDIT_RETURN_EN
        , output credit_out
`endif
    );

endinterface

// File: rtl/router_fifo.sv
// Show-ahead flit FIFO: the oldest entry is always visible on dout.
// Any DEPTH >= 2 is allowed; pointers wrap explicitly at DEPTH-1.
module router_fifo #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; push+pop together leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/router_input_port.sv
// Mesh router input port: buffers incoming flits, XY-routes each head flit,
// requests the output from the switch allocator and streams the packet
// wormhole-style until its tail flit leaves.
// Optional build macro CREDIT_RETURN_EN adds credit_out, one pulse per popped flit.
module router_input_port
    import router_pkg::*;
#(
    parameter int NUM_DIR = 5,
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int MESH_X  = 4,
    parameter int MESH_Y  = 4,
    parameter int COORD_W = $clog2((MESH_X > MESH_Y) ? MESH_X : MESH_Y)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [COORD_W-1:0]  x_cur,
    input  logic [COORD_W-1:0]  y_cur,
    router_input_port_if.slave  port
);

    localparam int DEST_X_MSB = WIDTH - 1 - TYPE_W;
    localparam int DEST_Y_MSB = DEST_X_MSB - COORD_W;

    logic [WIDTH-1:0]   fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic [TYPE_W-1:0]  front_type;
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
    logic [NUM_DIR-1:0] route_d;
    logic [NUM_DIR-1:0] route_q;
    logic               drop;
    logic               fwd_pop;
    logic               pop;
    state_e             state_q;

    router_fifo #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (port.in_valid),
        .din   (port.in_flit),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign front_type = fifo_dout[WIDTH-1 -: TYPE_W];
    assign dest_x     = fifo_dout[DEST_X_MSB -: COORD_W];
    assign dest_y     = fifo_dout[DEST_Y_MSB -: COORD_W];

    // Stray body/tail flits at the front while idle are discarded; forwarding
    // pops only while the packet owns the output. Reset masks both.
    assign drop    = !rst && (state_q == ST_IDLE) && !fifo_empty && !is_head(front_type);
    assign fwd_pop = !rst && (state_q == ST_ACTIVE) && !fifo_empty && port.out_ready;
    assign pop     = drop || fwd_pop;

    assign port.in_ready  = !fifo_full;
    assign port.out_flit  = fifo_dout;
    assign port.out_valid = (state_q == ST_ACTIVE) && !fifo_empty;
    assign port.req       = (state_q == ST_REQ);
    assign port.req_dir   = ((state_q == ST_REQ) || (state_q == ST_ACTIVE)) ? route_q : '0;
    assign port.err_drop  = drop;
`ifdef CREDIT_RETURN_EN
    assign port.credit_out = pop;
`endif

    // Dimension-ordered XY routing of the head flit at the FIFO front
    always_comb begin
        route_d = '0;
        if (dest_x > x_cur) begin
            route_d[DIR_XP] = 1'b1;
        end else if (dest_x < x_cur) begin
            route_d[DIR_XM] = 1'b1;
        end else if (dest_y > y_cur) begin
            route_d[DIR_YP] = 1'b1;
        end else if (dest_y < y_cur) begin
            route_d[DIR_YM] = 1'b1;
        end else begin
            route_d[DIR_LOCAL] = 1'b1;
        end
    end

    // Packet controller: wait for a head, route it, win the allocator, stream to tail
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            route_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty && is_head(front_type)) begin
                        state_q <= ST_ROUTE;
                    end
                end
                ST_ROUTE: begin
                    route_q <= route_d;
                    state_q <= ST_REQ;
                end
                ST_REQ: begin
                    if (port.grant) begin
                        state_q <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (fwd_pop && is_tail(front_type)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_input_port.sv
// Self-checking bench for router_input_port: routing table, hand-written
// multi-cycle sequences and a randomized stream against a packet-level model.
// Credit checks are compiled in when CREDIT_RETURN_EN is defined.
module tb_router_input_port;
    import router_pkg::*;

    localparam int NUM_DIR = 5;
    localparam int WIDTH   = 16;
    localparam int DEPTH   = 8;
    localparam int MESH_X  = 4;
    localparam int MESH_Y  = 4;
    localparam int COORD_W = 2;
    localparam int PL_W    = WIDTH - 2 - 2 * COORD_W;

    typedef struct {
        int                 cx;
        int                 cy;
        int                 dx;
        int                 dy;
        logic [NUM_DIR-1:0] exp_dir;
    } route_vec_t;

    typedef struct {
        logic [WIDTH-1:0]   flit;
        bit                 is_drop;
        logic [NUM_DIR-1:0] dir;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [COORD_W-1:0] x_cur = '0;
    logic [COORD_W-1:0] y_cur = '0;
    int                 errors = 0;
    int                 checks = 0;
    exp_t               sb[$];
    bit                 in_pkt;
    logic [NUM_DIR-1:0] pkt_dir;

    router_input_port_if #(.WIDTH(WIDTH), .NUM_DIR(NUM_DIR)) port_if ();

    router_input_port #(
        .NUM_DIR (NUM_DIR),
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .MESH_X  (MESH_X),
        .MESH_Y  (MESH_Y)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .x_cur (x_cur),
        .y_cur (y_cur),
        .port  (port_if)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] mkFlit(input flit_type_e t, input int dx, input int dy, input int pl);
        logic [COORD_W-1:0] xb;
        logic [COORD_W-1:0] yb;
        logic [PL_W-1:0]    pb;
        xb = COORD_W'(dx);
        yb = COORD_W'(dy);
        pb = PL_W'(pl);
        return {t, xb, yb, pb};
    endfunction

    // XY rule stated directly: go along X first, then Y, else deliver locally
    function automatic logic [NUM_DIR-1:0] refRoute(input int cx, input int cy, input int dx, input int dy);
        int idx;
        if (dx != cx)      idx = (dx > cx) ? 0 : 1;
        else if (dy != cy) idx = (dy > cy) ? 2 : 3;
        else               idx = 4;
        return NUM_DIR'(1 << idx);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive inputs at the falling edge, then settle so outputs can be sampled
    task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] f, input logic ordy, input logic gnt);
        @(negedge clk);
        port_if.in_valid  = iv;
        port_if.in_flit   = f;
        port_if.out_ready = ordy;
        port_if.grant     = gnt;
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
    endtask

    // Scoreboard update for one sampled cycle of the randomized run
    task automatic observeCycle();
        exp_t e;
        if (port_if.err_drop) begin
            if (sb.size() == 0) begin
                checkOutput("drop_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("drop_kind", 1, 32'(e.is_drop));
                checkOutput("drop_flit", 32'(port_if.out_flit), 32'(e.flit));
            end
        end
        if (port_if.out_valid && port_if.out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("fwd_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("fwd_kind", 0, 32'(e.is_drop));
                checkOutput("fwd_flit", 32'(port_if.out_flit), 32'(e.flit));
                checkOutput("fwd_dir", 32'(port_if.req_dir), 32'(e.dir));
            end
        end
`ifdef CREDIT_RETURN_EN
        checkOutput("credit_align", 32'(port_if.credit_out),
                    32'(port_if.err_drop || (port_if.out_valid && port_if.out_ready)));
`endif
    endtask

    // Packet-level model of an accepted flit: stray flits outside a packet drop,
    // everything from a head up to and including a tail follows the head's route
    task automatic modelPush(input logic [WIDTH-1:0] f, input flit_type_e t, input int dx, input int dy);
        exp_t e;
        e.flit = f;
        if (!in_pkt) begin
            if (t == FLIT_HEAD || t == FLIT_HEAD_TAIL) begin
                pkt_dir   = refRoute(int'(x_cur), int'(y_cur), dx, dy);
                e.is_drop = 1'b0;
                e.dir     = pkt_dir;
                in_pkt    = (t == FLIT_HEAD);
            end else begin
                e.is_drop = 1'b1;
                e.dir     = '0;
            end
        end else begin
            e.is_drop = 1'b0;
            e.dir     = pkt_dir;
            if (t == FLIT_TAIL || t == FLIT_HEAD_TAIL) in_pkt = 1'b0;
        end
        sb.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        route_vec_t       vecs[9];
        logic [WIDTH-1:0] hflit, bflit, tflit, xflit, f;
        logic [WIDTH-1:0] bodies[8];
        int               credits;
        int               budget;
        flit_type_e       t;
        int               dx, dy;
        logic             iv, ordy, gnt;

        vecs[0] = '{1, 1, 3, 1, 5'b00001};
        vecs[1] = '{2, 1, 0, 3, 5'b00010};
        vecs[2] = '{1, 1, 1, 3, 5'b00100};
        vecs[3] = '{2, 2, 2, 0, 5'b01000};
        vecs[4] = '{2, 2, 2, 2, 5'b10000};
        vecs[5] = '{0, 0, 3, 3, 5'b00001};
        vecs[6] = '{3, 0, 3, 3, 5'b00100};
        vecs[7] = '{3, 3, 0, 0, 5'b00010};
        vecs[8] = '{0, 3, 0, 0, 5'b01000};

        port_if.in_valid  = 1'b0;
        port_if.in_flit   = '0;
        port_if.out_ready = 1'b0;
        port_if.grant     = 1'b0;

        // Three-flit packet from (1,1) to (3,1) leaves through X+
        doReset();
        checkOutput("rst_in_ready", 32'(port_if.in_ready), 1);
        checkOutput("rst_req", 32'(port_if.req), 0);
        checkOutput("rst_req_dir", 32'(port_if.req_dir), 0);
        checkOutput("rst_out_valid", 32'(port_if.out_valid), 0);
        checkOutput("rst_err_drop", 32'(port_if.err_drop), 0);
`ifdef CREDIT_RETURN_EN
        checkOutput("rst_credit", 32'(port_if.credit_out), 0);
`endif
        x_cur = 2'd1;
        y_cur = 2'd1;
        hflit = mkFlit(FLIT_HEAD, 3, 1, 'h011);
        bflit = mkFlit(FLIT_BODY, 0, 0, 'h022);
        tflit = mkFlit(FLIT_TAIL, 0, 0, 'h033);
        credits = 0;
        applyStimulus(1'b1, hflit, 1'b1, 1'b0);
        applyStimulus(1'b1, bflit, 1'b1, 1'b0);
        applyStimulus(1'b1, tflit, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("pkt3_req", 32'(port_if.req), 1);
        checkOutput("pkt3_req_dir", 32'(port_if.req_dir), 32'b00001);
        bodies[0] = hflit;
        bodies[1] = bflit;
        bodies[2] = tflit;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkOutput("pkt3_out_valid", 32'(port_if.out_valid), 1);
            checkOutput("pkt3_out_flit", 32'(port_if.out_flit), 32'(bodies[k]));
            checkOutput("pkt3_dir_held", 32'(port_if.req_dir), 32'b00001);
`ifdef CREDIT_RETURN_EN
            if (port_if.credit_out) credits++;
`endif
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("pkt3_idle_out_valid", 32'(port_if.out_valid), 0);
        checkOutput("pkt3_idle_req_dir", 32'(port_if.req_dir), 0);
`ifdef CREDIT_RETURN_EN
        if (port_if.credit_out) credits++;
        checkOutput("pkt3_credit_count", 32'(credits), 3);
`endif

        // Routing table: single head+tail flits, also checks 4-cycle latency
        foreach (vecs[i]) begin
            doReset();
            x_cur = COORD_W'(vecs[i].cx);
            y_cur = COORD_W'(vecs[i].cy);
            f = mkFlit(FLIT_HEAD_TAIL, vecs[i].dx, vecs[i].dy, 'h200 + i);
            applyStimulus(1'b1, f, 1'b1, 1'b0);
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkOutput("route_no_early_req", 32'(port_if.req), 0);
            applyStimulus(1'b0, '0, 1'b1, 1'b1);
            checkOutput("route_req", 32'(port_if.req), 1);
            checkOutput($sformatf("route_dir[%0d]", i), 32'(port_if.req_dir), 32'(vecs[i].exp_dir));
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkOutput("route_out_valid", 32'(port_if.out_valid), 1);
            checkOutput("route_out_flit", 32'(port_if.out_flit), 32'(f));
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkOutput("route_back_idle", 32'(port_if.out_valid), 0);
            checkOutput("route_dir_cleared", 32'(port_if.req_dir), 0);
        end

        // Fill to DEPTH, reject the extra flit, then drain across the pointer wrap
        doReset();
        x_cur = 2'd0;
        y_cur = 2'd0;
        bodies[0] = mkFlit(FLIT_HEAD, 1, 0, 'h100);
        for (int k = 1; k < DEPTH; k++) bodies[k] = mkFlit(FLIT_BODY, 0, 0, 'h100 + k);
        xflit = mkFlit(FLIT_BODY, 0, 0, 'h3FF);
        tflit = mkFlit(FLIT_TAIL, 0, 0, 'h1AA);
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1'b1, bodies[k], 1'b0, 1'b0);
            checkOutput("fill_in_ready", 32'(port_if.in_ready), 1);
        end
        applyStimulus(1'b1, xflit, 1'b0, 1'b1);
        checkOutput("full_in_ready", 32'(port_if.in_ready), 0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("full_still_blocked", 32'(port_if.in_ready), 0);
        checkOutput("full_head_out", 32'(port_if.out_flit), 32'(bodies[0]));
        applyStimulus(1'b1, tflit, 1'b1, 1'b0);
        checkOutput("pop_frees_slot", 32'(port_if.in_ready), 1);
        checkOutput("drain_flit_1", 32'(port_if.out_flit), 32'(bodies[1]));
        for (int k = 2; k < DEPTH; k++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkOutput("drain_flit", 32'(port_if.out_flit), 32'(bodies[k]));
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("wrap_tail_valid", 32'(port_if.out_valid), 1);
        checkOutput("wrap_tail_flit", 32'(port_if.out_flit), 32'(tflit));
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("wrap_done_idle", 32'(port_if.out_valid), 0);
        checkOutput("extra_not_stored", 32'(port_if.err_drop), 0);

        // Stray body flit at the front while idle is dropped with one pulse
        doReset();
        bflit = mkFlit(FLIT_BODY, 2, 2, 'h0BD);
        applyStimulus(1'b1, bflit, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("drop_pulse", 32'(port_if.err_drop), 1);
        checkOutput("drop_visible_flit", 32'(port_if.out_flit), 32'(bflit));
        checkOutput("drop_no_req", 32'(port_if.req), 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("drop_pulse_end", 32'(port_if.err_drop), 0);
        checkOutput("drop_gone", 32'(port_if.out_valid), 0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("drop_still_no_req", 32'(port_if.req), 0);

        // Reset in the middle of a packet discards the five queued flits
        doReset();
        x_cur = 2'd1;
        y_cur = 2'd1;
        applyStimulus(1'b1, mkFlit(FLIT_HEAD, 0, 1, 'h050), 1'b0, 1'b0);
        for (int k = 1; k < 6; k++) begin
            applyStimulus(1'b1, mkFlit(FLIT_BODY, 0, 0, 'h050 + k), 1'b0, (k == 3) ? 1'b1 : 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("midrst_active", 32'(port_if.out_valid), 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("midrst_dir_held", 32'(port_if.req_dir), 32'b00010);
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("midrst_req", 32'(port_if.req), 0);
        checkOutput("midrst_out_valid", 32'(port_if.out_valid), 0);
        checkOutput("midrst_in_ready", 32'(port_if.in_ready), 1);
        checkOutput("midrst_req_dir", 32'(port_if.req_dir), 0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("midrst_fifo_empty", 32'(port_if.err_drop), 0);
        checkOutput("midrst_idle", 32'(port_if.out_valid), 0);

        // Randomized stream of packets and stray flits against the packet model
        doReset();
        x_cur = COORD_W'($urandom_range(0, 3));
        y_cur = COORD_W'($urandom_range(0, 3));
        sb.delete();
        in_pkt = 1'b0;
        pkt_dir = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            case ($urandom_range(0, 9))
                0, 1:       t = FLIT_HEAD;
                2:          t = FLIT_HEAD_TAIL;
                3, 4:       t = FLIT_TAIL;
                default:    t = FLIT_BODY;
            endcase
            dx   = int'($urandom_range(0, 3));
            dy   = int'($urandom_range(0, 3));
            f    = mkFlit(t, dx, dy, int'($urandom_range(0, 1023)));
            iv   = ($urandom_range(0, 99) < 60);
            ordy = ($urandom_range(0, 99) < 70);
            gnt  = ($urandom_range(0, 99) < 50);
            applyStimulus(iv, f, ordy, gnt);
            observeCycle();
            if (iv && port_if.in_ready) modelPush(f, t, dx, dy);
        end
        budget = 0;
        while (sb.size() > 0 && budget < 400) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b1);
            observeCycle();
            budget++;
        end
        checkOutput("random_drained", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
